// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, shift schedule,
// sizes, FSM state type and the 28-bit half rotations.
package des_pkg;

    localparam int KEY_W  = 56;
    localparam int HALF_W = 28;
    localparam int SK_W   = 48;
    localparam int ROUNDS = 16;

    // PC-1 over the parity-stripped key: entry i names the stripped DES bit
    // (1 = MSB) that lands in output bit i+1.
    localparam int PC1 [KEY_W] = '{
        50, 43, 36, 29, 22, 15,  8,
         1, 51, 44, 37, 30, 23, 16,
         9,  2, 52, 45, 38, 31, 24,
        17, 10,  3, 53, 46, 39, 32,
        56, 49, 42, 35, 28, 21, 14,
         7, 55, 48, 41, 34, 27, 20,
        13,  6, 54, 47, 40, 33, 26,
        19, 12,  5, 25, 18, 11,  4
    };

    localparam int PC2 [SK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-shift amount of rounds 1..16, stored 0-based.
    localparam int SHIFTS [ROUNDS] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic is_double(input logic [3:0] idx);
        return SHIFTS[idx] == 2;
    endfunction

    function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
        return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression of the 56-bit C||D register into a 48-bit round subkey.
// Pure wiring; DES bit 1 is the MSB on both sides.
module des_pc2
    import des_pkg::*;
(
    input  logic [KEY_W-1:0] cd,
    output logic [SK_W-1:0]  subkey
);

    for (genvar i = 0; i < SK_W; i++) begin : g_pc2
        assign subkey[SK_W-1-i] = cd[KEY_W-PC2[i]];
    end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: one C/D pair rotated in place, one
// subkey per valid/ready handshake, forward or reverse order.
module des_key_schedule #(
    parameter int KEY_W = 56,
    parameter int SK_W  = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [KEY_W-1:0] key,
    input  logic             decrypt,
    output logic             sk_valid,
    input  logic             sk_ready,
    output logic [SK_W-1:0]  subkey,
    output logic [3:0]       round,
    output logic             last,
    output logic             busy
);

    localparam int HALF_W = des_pkg::HALF_W;
    localparam logic [3:0] LAST_IDX = 4'(des_pkg::ROUNDS - 1);

    des_pkg::state_t   state;
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    logic [3:0]        round_q;
    logic              dec_q;

    logic [KEY_W-1:0]  pc1_key;
    logic [HALF_W-1:0] c0;
    logic [HALF_W-1:0] d0;
    logic              xfer;
    logic              at_end;
    logic              enc_two;
    logic              dec_two;

    for (genvar i = 0; i < KEY_W; i++) begin : g_pc1
        assign pc1_key[KEY_W-1-i] = key[KEY_W-des_pkg::PC1[i]];
    end

    assign c0 = pc1_key[KEY_W-1:HALF_W];
    assign d0 = pc1_key[HALF_W-1:0];

    assign xfer   = (state == des_pkg::RUN) && sk_ready;
    assign at_end = dec_q ? (round_q == 4'd0) : (round_q == LAST_IDX);

    // Encrypt moves on to the next round's shift; decrypt undoes the shift
    // of the round just delivered.
    assign enc_two = des_pkg::is_double(round_q + 4'd1);
    assign dec_two = des_pkg::is_double(round_q);

    // NOTE: async reset sits in the sensitivity list, and every state
    // register is updated with <= so all of them see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= des_pkg::IDLE;
            c       <= '0;
            d       <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
        end else if (key_load) begin
            state <= des_pkg::RUN;
            dec_q <= decrypt;
            if (decrypt) begin
                // The 28 total shifts return C,D to C0,D0, so K16 is PC-2 of PC-1.
                c       <= c0;
                d       <= d0;
                round_q <= LAST_IDX;
            end else begin
                c       <= des_pkg::rotl(c0, 1'b0);
                d       <= des_pkg::rotl(d0, 1'b0);
                round_q <= 4'd0;
            end
        end else if (xfer) begin
            if (dec_q) begin
                c       <= des_pkg::rotr(c, dec_two);
                d       <= des_pkg::rotr(d, dec_two);
                round_q <= round_q - 4'd1;
            end else begin
                c       <= des_pkg::rotl(c, enc_two);
                d       <= des_pkg::rotl(d, enc_two);
                round_q <= round_q + 4'd1;
            end
            if (at_end) begin
                state <= des_pkg::IDLE;
            end
        end
    end

    des_pc2 u_pc2 (
        .cd     ({c, d}),
        .subkey (subkey)
    );

    assign busy     = (state == des_pkg::RUN);
    assign sk_valid = busy;
    assign round    = round_q;
    assign last     = sk_valid && at_end;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule: known-answer schedules, backpressure,
// abort, asynchronous reset and weak keys.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic [55:0] key;
    logic        decrypt;
    logic        sk_valid;
    logic        sk_ready;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        last;
    logic        busy;

    int total = 0;
    int bad   = 0;

    localparam logic [55:0] TEST_KEY = 56'h12695BC9B7B7F8;
    localparam logic [55:0] ONES_KEY = 56'hFFFFFFFFFFFFFF;
    localparam logic [47:0] ONES_SK  = 48'hFFFFFFFFFFFF;

    // Published subkeys K1..K16 of DES key 133457799BBCDFF1.
    logic [47:0] ks [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct {
        string       name;
        logic [55:0] key;
        logic        dec;
        bit          use_table;
        logic [47:0] exp_first;
        logic [47:0] exp_16th;
    } sched_vec_t;

    sched_vec_t vecs [6];

    des_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .key_load (key_load),
        .key      (key),
        .decrypt  (decrypt),
        .sk_valid (sk_valid),
        .sk_ready (sk_ready),
        .subkey   (subkey),
        .round    (round),
        .last     (last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Leaves the bench at edge+1 after the capturing edge.
    task automatic load(input logic [55:0] k, input logic dec);
        @(posedge clk);
        #1;
        key      = k;
        decrypt  = dec;
        key_load = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0;
    endtask

    task automatic run_vec(input sched_vec_t v);
        logic [47:0] exp_sk;
        logic [3:0]  exp_rd;
        sk_ready = 1'b1;
        load(v.key, v.dec);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (v.use_table) exp_sk = v.dec ? ks[15-i] : ks[i];
            else             exp_sk = v.exp_first;
            exp_rd = v.dec ? 4'(15 - i) : 4'(i);
            check($sformatf("%s valid[%0d]", v.name, i), 64'(sk_valid), 64'(1));
            check($sformatf("%s subkey[%0d]", v.name, i), 64'(subkey), 64'(exp_sk));
            check($sformatf("%s round[%0d]", v.name, i), 64'(round), 64'(exp_rd));
            check($sformatf("%s last[%0d]", v.name, i), 64'(last), 64'(i == 15));
            if (i == 0)  check($sformatf("%s first", v.name), 64'(subkey), 64'(v.exp_first));
            if (i == 15) check($sformatf("%s 16th", v.name), 64'(subkey), 64'(v.exp_16th));
        end
        @(negedge clk);
        check($sformatf("%s done valid", v.name), 64'(sk_valid), 64'(0));
        check($sformatf("%s done busy", v.name), 64'(busy), 64'(0));
        check($sformatf("%s done last", v.name), 64'(last), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int xfers;

        vecs[0] = '{"enc_test",  TEST_KEY, 1'b0, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5};
        vecs[1] = '{"dec_test",  TEST_KEY, 1'b1, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072};
        vecs[2] = '{"enc_zero",  56'h0,    1'b0, 1'b0, 48'h0,            48'h0};
        vecs[3] = '{"enc_ones",  ONES_KEY, 1'b0, 1'b0, ONES_SK,          ONES_SK};
        vecs[4] = '{"dec_zero",  56'h0,    1'b1, 1'b0, 48'h0,            48'h0};
        vecs[5] = '{"dec_ones",  ONES_KEY, 1'b1, 1'b0, ONES_SK,          ONES_SK};

        rst      = 1'b1;
        key_load = 1'b0;
        key      = '0;
        decrypt  = 1'b0;
        sk_ready = 1'b0;

        #1;
        check("reset valid",  64'(sk_valid), 64'(0));
        check("reset busy",   64'(busy),     64'(0));
        check("reset round",  64'(round),    64'(0));
        check("reset last",   64'(last),     64'(0));
        check("reset subkey", 64'(subkey),   64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Backpressure: random ready, outputs must hold while ready is low.
        idx      = 0;
        xfers    = 0;
        sk_ready = 1'b0;
        load(TEST_KEY, 1'b0);
        for (int cyc = 0; cyc < 200 && idx < 16; cyc++) begin
            @(negedge clk);
            check($sformatf("bp valid c%0d", cyc), 64'(sk_valid), 64'(1));
            check($sformatf("bp subkey c%0d", cyc), 64'(subkey), 64'(ks[idx]));
            check($sformatf("bp round c%0d", cyc), 64'(round), 64'(idx));
            if (sk_valid && sk_ready) begin
                idx++;
                xfers++;
            end
            @(posedge clk);
            #1;
            sk_ready = (cyc < 3) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        check("bp transfers", 64'(xfers), 64'(16));
        @(negedge clk);
        check("bp done valid", 64'(sk_valid), 64'(0));

        // Abort at round 7: the new key wins over the concurrent transfer.
        sk_ready = 1'b1;
        load(TEST_KEY, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("abort pre round",  64'(round),  64'(7));
        check("abort pre subkey", 64'(subkey), 64'(ks[7]));
        key      = ONES_KEY;
        decrypt  = 1'b0;
        key_load = 1'b1;
        @(posedge clk);
        #1;
        key_load = 1'b0;
        @(negedge clk);
        check("abort valid",  64'(sk_valid), 64'(1));
        check("abort subkey", 64'(subkey),   64'(ONES_SK));
        check("abort round",  64'(round),    64'(0));
        @(negedge clk);
        check("abort next round", 64'(round), 64'(1));

        // Asynchronous reset mid-run, then silence until the next key_load.
        load(TEST_KEY, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst pre round", 64'(round), 64'(5));
        #1;
        rst = 1'b1;
        #1;
        check("rst async valid",  64'(sk_valid), 64'(0));
        check("rst async busy",   64'(busy),     64'(0));
        check("rst async round",  64'(round),    64'(0));
        check("rst async subkey", 64'(subkey),   64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst idle valid %0d", i), 64'(sk_valid), 64'(0));
        end
        load(TEST_KEY, 1'b0);
        @(negedge clk);
        check("rst reload subkey", 64'(subkey), 64'(ks[0]));
        check("rst reload round",  64'(round),  64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES subkey generator sitting directly upstream of the DES round datapath. Loads a 56-bit key, applies PC-1, then delivers the sixteen 48-bit round subkeys one per handshake over a valid/ready interface: K1..K16 in encrypt mode, K16..K1 in decrypt mode. Only one C/D register pair is held, and subkeys are produced by rotation rather than stored, so the round core consumes one subkey per round without a 768-bit key table.

## Interface
Parameters:
- KEY_W, 56, key width (parity-stripped)
- SK_W, 48, subkey width

Ports:
- clk  in  1  clock; all state is updated on the rising edge
- rst  in  1  asynchronous, active-high reset
- key_load  in  1  single-cycle pulse; captures key and decrypt
- key  in  56  the 64-bit DES key with parity bits 8,16,…,64 removed, MSB-first (DES bit 1 = key[55])
- decrypt  in  1  0 = encrypt order (K1→K16), 1 = decrypt order (K16→K1); sampled only on key_load
- sk_valid  out  1  subkey holds a valid round key
- sk_ready  in  1  consumer accepts the current subkey
- subkey  out  48  PC-2(C,D), DES bit 1 = subkey[47]
- round  out  4  index of the current subkey minus 1 (K1→0, K16→15)
- last  out  1  sk_valid && this is the 16th subkey delivered
- busy  out  1  schedule loaded and not yet completed

## Operation
- States: IDLE, RUN.
- Shift schedule: S[r] = 1 for r ∈ {1,2,9,16}, otherwise 2. The sum over all 16 rounds is 28.
- key_load, in any state:
  - C,D ← PC-1(key).
  - Encrypt: apply rotl by S[1]; round ← 0.
  - Decrypt: no rotation (a full 28-bit cycle gives K16 = PC-2(C0,D0)); round ← 15.
  - Then → RUN.
- RUN: sk_valid = 1 and subkey = PC-2(C,D), driven combinationally from the registers.
- Transfer occurs when sk_valid && sk_ready:
  - Encrypt: round ← round+1; C,D ← rotl by S[round+2].
  - Decrypt: C,D ← rotr by S[round+1] (the shift of the round just delivered); round ← round−1.
- After the 16th transfer: → IDLE, sk_valid = 0. round and C,D are held but are don't-care.
- key_load in RUN aborts the current schedule and restarts with the new key. key_load has priority over a simultaneous transfer; the transfer is dropped.
- sk_ready while sk_valid = 0 is ignored.
- While sk_ready is low, subkey, round and sk_valid are held stable.
- Rotations are independent 28-bit circular shifts of C and D. No carry between halves.
- busy = (state == RUN).

## Timing
- Reset values: state IDLE, C = D = 0, round = 0, sk_valid = 0, last = 0, busy = 0. subkey = PC-2(0) = 0.
- Latency: key_load sampled at edge n gives a valid K1 (or K16 in decrypt) after edge n, with no wait state.
- Throughput: one subkey per cycle when sk_ready is held high. A complete schedule takes 16 consecutive transfer cycles.
- Reset asserted mid-schedule clears the block immediately, asynchronously. The first key_load after deassertion behaves as from IDLE.
- No combinational path from sk_ready to sk_valid or subkey.

## Structure
- Package des_pkg holds:
  - PC1 table (56 entries, remapped to the parity-stripped indexing)
  - PC2 table (48 entries)
  - shift schedule S[1..16]
  - constants KEY_W, HALF_W = 28, SK_W, ROUNDS = 16
  - state enum
- One combinational sub-module, des_pc2 (56→48 permutation), reused by the verification model.
- PC-1 and the rotations stay inline.

## Test plan
- Encrypt, key = 0x12695BC9B7B7F8 (DES key 133457799BBCDFF1), decrypt = 0, sk_ready held at 1:
  - cycle 1: subkey = 0x1B02EFFC7072, round = 0
  - 16th cycle: subkey = 0xCB3D8B0E17F5, round = 15, last = 1
  - next cycle: sk_valid = 0, busy = 0
- Decrypt, same key: first subkey = 0xCB3D8B0E17F5 with round = 15; 16th subkey = 0x1B02EFFC7072 with last = 1. The full sequence equals the encrypt sequence reversed.
- Backpressure: toggle sk_ready pseudo-randomly. subkey and round stay stable while ready is low, and exactly 16 distinct transfers occur, matching the reference model.
- Abort: key_load with a new key at round 7 while sk_ready = 1 → next cycle subkey = K1 of the new key, round = 0. The old transfer is not counted.
- Reset mid-run: assert rst asynchronously at round 5 → sk_valid, busy and round are 0 before the next edge. After release, no output appears until key_load.
- All-zero key → all 16 subkeys = 0; all-ones key (0xFFFFFFFFFFFFFF) → all 16 subkeys = 0xFFFFFFFFFFFF. Checks weak-key handling and last timing.
